// File: rtl/traffic_light_monitor_if.sv
// Light-code bus between the traffic light controller side and the monitor.
// The master drives the light codes and error clear; the monitor reports phase and errors back.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       ns_light;
    logic [1:0]       ew_light;
    logic             clear_err;
    logic [1:0]       phase;
    logic             locked;
    logic [3:0]       err_pulse;
    logic [3:0]       err_status;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output ns_light, ew_light, clear_err,
        input  phase, locked, err_pulse, err_status, cycle_count
    );

    modport slave (
        input  ns_light, ew_light, clear_err,
        output phase, locked, err_pulse, err_status, cycle_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the controller's ns/ew light codes: locks onto the phase
// sequence and flags conflict, illegal-code, sequence and phase-duration violations.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int RUN_W         = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_light_monitor_if.slave mon
);
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] GREEN_DUR = RUN_W'(GREEN_CYCLES);
    localparam logic [RUN_W-1:0] YELOW_DUR = RUN_W'(YELLOW_CYCLES);

    typedef enum logic { SYNC, TRACK } state_t;

    // Legal phases share the phase output encoding, so sample_bits[1:0] is the phase.
    typedef enum logic [2:0] {
        S_NSG      = 3'd0,
        S_NSY      = 3'd1,
        S_EWG      = 3'd2,
        S_EWY      = 3'd3,
        S_ALL_RED  = 3'd4,
        S_CONFLICT = 3'd5,
        S_ILLEGAL  = 3'd6
    } sample_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             first_q, first_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [3:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sample_t          sample;
    logic [2:0]       sample_bits;
    logic [1:0]       sample_phase;
    logic [RUN_W-1:0] dur, run_inc;

    always_comb begin
        sample = S_ALL_RED;
        if (mon.ns_light == 2'b11 || mon.ew_light == 2'b11) sample = S_ILLEGAL;
        else if (mon.ns_light != 2'b00 && mon.ew_light != 2'b00) sample = S_CONFLICT;
        else if (mon.ns_light == 2'b10) sample = S_NSG;
        else if (mon.ns_light == 2'b01) sample = S_NSY;
        else if (mon.ew_light == 2'b10) sample = S_EWG;
        else if (mon.ew_light == 2'b01) sample = S_EWY;
    end

    assign sample_bits  = sample;
    assign sample_phase = sample_bits[1:0];
    assign dur          = phase_q[0] ? YELOW_DUR : GREEN_DUR;
    assign run_inc      = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        run_d   = run_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        pulse_d = 4'b0000;

        unique case (sample)
            S_ILLEGAL, S_CONFLICT, S_ALL_RED: begin
                pulse_d = (sample == S_ILLEGAL)  ? 4'b0010 :
                          (sample == S_CONFLICT) ? 4'b0001 : 4'b0100;
                state_d = SYNC;
                run_d   = '0;
            end
            default: begin
                if (state_q == SYNC) begin
                    state_d = TRACK;
                    phase_d = sample_phase;
                    run_d   = RUN_ONE;
                    first_d = 1'b1;
                end else if (sample_phase == phase_q) begin
                    // Run length crosses dur+1 exactly once per phase; saturation stops repeats.
                    run_d = run_inc;
                    if (run_inc != run_q && run_inc == dur + RUN_ONE) pulse_d = 4'b1000;
                end else if (sample_phase == phase_q + 2'd1) begin
                    if (!first_q && run_q < dur) pulse_d = 4'b1000;
                    if (phase_q == 2'b11) cnt_d = cnt_q + CNT_W'(1);
                    phase_d = sample_phase;
                    run_d   = RUN_ONE;
                    first_d = 1'b0;
                end else begin
                    pulse_d = 4'b0100;
                    phase_d = sample_phase;
                    run_d   = RUN_ONE;
                    first_d = 1'b1;
                end
            end
        endcase

        status_d = (mon.clear_err ? 4'b0000 : status_q) | pulse_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SYNC;
            phase_q  <= 2'b00;
            run_q    <= '0;
            first_q  <= 1'b0;
            pulse_q  <= 4'b0000;
            status_q <= 4'b0000;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            run_q    <= run_d;
            first_q  <= first_d;
            pulse_q  <= pulse_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mon.phase       = phase_q;
    assign mon.locked      = (state_q == TRACK);
    assign mon.err_pulse   = pulse_q;
    assign mon.err_status  = status_q;
    assign mon.cycle_count = cnt_q;
endmodule
